mem_port_arbiter: RTL and testbench

Shares one single-ported, variable-latency unified memory between the five-stage CPU's instruction-fetch (IF) port and data-access (MEM) port. Accepts level requests from both stages and grants one at a time, alternating when both are pending. Drives a req/ack handshake to memory and returns per-port read data with a one-cycle done pulse. Produces per-stage stall signals that freeze the pipeline while an access is outstanding, and aborts accesses that are never acknowledged.

---
 rtl/mem_port_arbiter_pkg.sv | 24 ++
 rtl/mem_port_arbiter_ack_timer.sv | 35 +++
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter_pkg : shared types and constants for the IF/MEM arbiter
// Revision 1.0
// ============================================================================
package mem_port_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    typedef enum logic {
        OWN_IF   = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    localparam logic [1:0]  DIGIT_BYTE = 2'b00;
    localparam logic [1:0]  DIGIT_HALF = 2'b01;
    localparam logic [1:0]  DIGIT_WORD = 2'b10;
    localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_ack_timer.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter_ack_timer : 16-bit busy-cycle counter with expiry flag
// Revision 1.0
// ============================================================================
module mem_port_arbiter_ack_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [15:0] c_limit = 16'(TIMEOUT);

    logic [15:0] count_q;

    // Clear together with enable starts the count at 1 so the first
    // mem_req cycle is already counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 16'd0;
        end else if (clear_i) begin
            count_q <= enable_i ? 16'd1 : 16'd0;
        end else if (enable_i && (count_q != 16'hFFFF)) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign expired_o = (count_q == c_limit);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : alternating IF/data arbiter for one shared memory port
// Revision 1.0
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_done_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [1:0]  d_digit_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic [31:0] d_rdata_o,
    output logic        d_done_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [1:0]  mem_digit_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic        stall_if_o,
    output logic        stall_d_o,
    output logic        err_o
);

    state_e      state_q;
    owner_e      owner_q;
    owner_e      last_grant_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [1:0]  mem_digit_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] if_rdata_q;
    logic [31:0] d_rdata_q;
    logic        if_done_q;
    logic        d_done_q;
    logic        err_q;

    logic        if_elig;
    logic        d_elig;
    logic        grant_data;
    logic        grant_if;
    logic        finish;
    logic        expired;
    logic [31:0] result_data;

    // A port in its done cycle is not eligible, so a held req is not re-served.
    assign if_elig    = if_req_i & ~if_done_q;
    assign d_elig     = d_req_i & ~d_done_q;
    assign grant_data = (state_q == ST_IDLE) & d_elig &
                        (~if_elig | (last_grant_q != OWN_DATA));
    assign grant_if   = (state_q == ST_IDLE) & if_elig & ~grant_data;
    assign finish     = (state_q == ST_BUSY) & (mem_ack_i | expired);
    assign result_data = mem_ack_i ? mem_rdata_i : ABORT_DATA;

    mem_port_arbiter_ack_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_ack_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (grant_data | grant_if | finish),
        .enable_i  (grant_data | grant_if | ((state_q == ST_BUSY) & ~finish)),
        .expired_o (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_IF;
            last_grant_q <= OWN_IF;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_digit_q  <= 2'b00;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            if_rdata_q   <= 32'd0;
            d_rdata_q    <= 32'd0;
            if_done_q    <= 1'b0;
            d_done_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_data) begin
                        mem_req_q    <= 1'b1;
                        mem_we_q     <= d_we_i;
                        mem_digit_q  <= d_digit_i;
                        mem_addr_q   <= d_addr_i;
                        mem_wdata_q  <= d_wdata_i;
                        owner_q      <= OWN_DATA;
                        last_grant_q <= OWN_DATA;
                        state_q      <= ST_BUSY;
                    end else if (grant_if) begin
                        mem_req_q    <= 1'b1;
                        mem_we_q     <= 1'b0;
                        mem_digit_q  <= DIGIT_WORD;
                        mem_addr_q   <= if_addr_i;
                        mem_wdata_q  <= 32'd0;
                        owner_q      <= OWN_IF;
                        last_grant_q <= OWN_IF;
                        state_q      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (finish) begin
                        mem_req_q <= 1'b0;
                        state_q   <= ST_IDLE;
                        if (!mem_ack_i) begin
                            err_q <= 1'b1;
                        end
                        if (owner_q == OWN_IF) begin
                            if_done_q  <= 1'b1;
                            if_rdata_q <= result_data;
                        end else begin
                            d_done_q <= 1'b1;
                            if (!mem_we_q) begin
                                d_rdata_q <= result_data;
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign if_rdata_o  = if_rdata_q;
    assign if_done_o   = if_done_q;
    assign d_rdata_o   = d_rdata_q;
    assign d_done_o    = d_done_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_digit_o = mem_digit_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign stall_if_o  = if_req_i & ~if_done_q;
    assign stall_d_o   = d_req_i & ~d_done_q;
    assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter : directed self-checking bench for mem_port_arbiter
// Revision 1.0
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_digit;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_digit;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall_if;
    logic        stall_d;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;

    mem_port_arbiter #(
        .TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_rdata_o  (if_rdata),
        .if_done_o   (if_done),
        .d_req_i     (d_req),
        .d_we_i      (d_we),
        .d_digit_i   (d_digit),
        .d_addr_i    (d_addr),
        .d_wdata_i   (d_wdata),
        .d_rdata_o   (d_rdata),
        .d_done_o    (d_done),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_digit_o (mem_digit),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .mem_ack_i   (mem_ack),
        .stall_if_o  (stall_if),
        .stall_d_o   (stall_d),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        n_checks++;
        if (obs !== exp_val) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp_val);
        end else begin
            n_pass++;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Called in a cycle where a load/fetch should be on the bus; acks it at
    // zero wait and returns in the owner's done cycle.
    task automatic serve(input string tag, input logic [31:0] exp_addr, input logic [31:0] rdata);
        check({tag, "_req"},  {31'd0, mem_req}, 32'd1);
        check({tag, "_addr"}, mem_addr, exp_addr);
        check({tag, "_we"},   {31'd0, mem_we}, 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        cyc();
        mem_ack   = 1'b0;
        check({tag, "_reqlow"}, {31'd0, mem_req}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; if_req = 1'b0; if_addr = 32'd0;
        d_req = 1'b0; d_we = 1'b0; d_digit = 2'b10; d_addr = 32'd0; d_wdata = 32'd0;
        mem_rdata = 32'd0; mem_ack = 1'b0;
        repeat (2) cyc();
        check("rst_mem_req",   {31'd0, mem_req}, 32'd0);
        check("rst_mem_digit", {30'd0, mem_digit}, 32'd0);
        check("rst_mem_addr",  mem_addr, 32'd0);
        check("rst_if_rdata",  if_rdata, 32'd0);
        check("rst_d_rdata",   d_rdata, 32'd0);
        check("rst_dones",     {30'd0, if_done, d_done}, 32'd0);
        check("rst_err",       {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        cyc();

        // IF only, zero-wait ack
        if_req = 1'b1; if_addr = 32'h10;
        #1;
        check("t1_stall_c0", {31'd0, stall_if}, 32'd1);
        check("t1_req_c0",   {31'd0, mem_req}, 32'd0);
        cyc();
        check("t1_req_c1",   {31'd0, mem_req}, 32'd1);
        check("t1_addr",     mem_addr, 32'h10);
        check("t1_digit",    {30'd0, mem_digit}, 32'd2);
        check("t1_stall_c1", {31'd0, stall_if}, 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
        cyc();
        check("t1_done",     {31'd0, if_done}, 32'd1);
        check("t1_rdata",    if_rdata, 32'h0050_0093);
        check("t1_stall_c2", {31'd0, stall_if}, 32'd0);
        if_req = 1'b0; mem_ack = 1'b0;
        cyc();
        check("t1_done_low", {31'd0, if_done}, 32'd0);

        // Contention 1: data wins after reset, IF follows back-to-back
        if_req = 1'b1; if_addr = 32'h20;
        d_req = 1'b1; d_addr = 32'h100;
        cyc();
        serve("c1_d", 32'h100, 32'h1111_0001);
        check("c1_d_done",  {31'd0, d_done}, 32'd1);
        check("c1_d_rdata", d_rdata, 32'h1111_0001);
        d_req = 1'b0;
        cyc();
        serve("c1_if", 32'h20, 32'h2222_0001);
        check("c1_if_done",  {31'd0, if_done}, 32'd1);
        check("c1_if_rdata", if_rdata, 32'h2222_0001);
        if_req = 1'b0;
        cyc();

        // Data-only access leaves last grant = DATA
        d_req = 1'b1; d_addr = 32'h104;
        cyc();
        serve("d_only", 32'h104, 32'h1111_0002);
        check("d_only_done", {31'd0, d_done}, 32'd1);
        d_req = 1'b0;
        cyc();

        // Contention 2: IF wins
        if_req = 1'b1; if_addr = 32'h24;
        d_req = 1'b1; d_addr = 32'h108;
        cyc();
        serve("c2_if", 32'h24, 32'h2222_0002);
        check("c2_if_done", {31'd0, if_done}, 32'd1);
        if_req = 1'b0;
        cyc();
        serve("c2_d", 32'h108, 32'h1111_0003);
        check("c2_d_rdata", d_rdata, 32'h1111_0003);
        d_req = 1'b0;
        cyc();

        // IF-only access leaves last grant = IF
        if_req = 1'b1; if_addr = 32'h28;
        cyc();
        serve("if_only", 32'h28, 32'h2222_0003);
        if_req = 1'b0;
        cyc();

        // Contention 3: data wins
        if_req = 1'b1; if_addr = 32'h2C;
        d_req = 1'b1; d_addr = 32'h10C;
        cyc();
        serve("c3_d", 32'h10C, 32'h4444_0004);
        check("c3_d_rdata", d_rdata, 32'h4444_0004);
        d_req = 1'b0;
        cyc();
        serve("c3_if", 32'h2C, 32'h2222_0004);
        check("c3_if_rdata", if_rdata, 32'h2222_0004);
        if_req = 1'b0;
        cyc();

        // Store, half-word, ack after 3 waits (coincides with timer = TIMEOUT)
        d_req = 1'b1; d_we = 1'b1; d_digit = 2'b01; d_addr = 32'h200; d_wdata = 32'h1234;
        #1;
        check("st_stall_c0", {31'd0, stall_d}, 32'd1);
        cyc();
        for (int i = 1; i <= 4; i++) begin
            check("st_req",   {31'd0, mem_req}, 32'd1);
            check("st_we",    {31'd0, mem_we}, 32'd1);
            check("st_digit", {30'd0, mem_digit}, 32'd1);
            check("st_addr",  mem_addr, 32'h200);
            check("st_wdata", mem_wdata, 32'h1234);
            check("st_done0", {31'd0, d_done}, 32'd0);
            if (i == 4) begin
                mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
            end
            cyc();
        end
        check("st_done",   {31'd0, d_done}, 32'd1);
        check("st_rdata",  d_rdata, 32'h4444_0004);
        check("st_err",    {31'd0, err}, 32'd0);
        check("st_reqlow", {31'd0, mem_req}, 32'd0);
        check("st_stall",  {31'd0, stall_d}, 32'd0);
        d_req = 1'b0; d_we = 1'b0; d_digit = 2'b10; mem_ack = 1'b0;
        cyc();

        // IF fetch never acknowledged: abort after 4 busy cycles
        if_req = 1'b1; if_addr = 32'h30;
        cyc();
        check("to_wdata", mem_wdata, 32'd0);
        check("to_digit", {30'd0, mem_digit}, 32'd2);
        for (int i = 1; i <= 4; i++) begin
            check("to_req",   {31'd0, mem_req}, 32'd1);
            check("to_done0", {31'd0, if_done}, 32'd0);
            cyc();
        end
        check("to_reqlow", {31'd0, mem_req}, 32'd0);
        check("to_done",   {31'd0, if_done}, 32'd1);
        check("to_rdata",  if_rdata, 32'hDEAD_BEEF);
        check("to_err",    {31'd0, err}, 32'd1);
        if_req = 1'b0;
        repeat (2) cyc();
        check("to_err_sticky", {31'd0, err}, 32'd1);

        // Reset mid-access
        d_req = 1'b1; d_addr = 32'h300;
        cyc();
        check("rm_req", {31'd0, mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rm_req_async", {31'd0, mem_req}, 32'd0);
        check("rm_err",       {31'd0, err}, 32'd0);
        d_req = 1'b0;
        cyc();
        check("rm_done_rst", {31'd0, d_done}, 32'd0);
        rst_n = 1'b1;
        cyc();
        check("rm_done_after", {31'd0, d_done}, 32'd0);
        check("rm_req_after",  {31'd0, mem_req}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
